// File: rtl/bf_pkg.sv
// Shared definitions for the bf16 MAC lane: data widths, sequencer state codes and NaN helper.
package bf_pkg;

    localparam int BF16_W = 16;
    localparam int FP32_W = 32;

    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

    // State codes are plain constants so older tools and netlists can match them by value.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    function automatic logic is_fp32_nan(input logic [FP32_W-1:0] value);
        return (value[30:23] == 8'hFF) && (value[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/bf_mac_seq.sv
// Dot-product sequencer feeding one bf16 MAC lane from two synchronous-read operand memories.
// Optional macro BF_SEQ_NAN_ABORT_EN adds res_nan and aborts a job once the accumulator turns NaN.
module bf_mac_seq
    import bf_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_a_addr,
    output logic [ADDR_W-1:0] mem_b_addr,
    input  logic [BF16_W-1:0] mem_a_rdata,
    input  logic [BF16_W-1:0] mem_b_rdata,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [BF16_W-1:0] mac_in_1,
    output logic [BF16_W-1:0] mac_in_2,
    input  logic [FP32_W-1:0] acc_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FP32_W-1:0] res_data
`ifdef BF_SEQ_NAN_ABORT_EN
    ,
    output logic              res_nan
`endif
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [LEN_W-1:0]  cnt;
    logic              mac_en_q;
    logic              nan_hit;
    logic              accept;

    assign accept = (state == IDLE) && start;

`ifdef BF_SEQ_NAN_ABORT_EN
    assign nan_hit = ((state == RUN) || (state == DRAIN)) && is_fp32_nan(acc_result);
`else
    assign nan_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = (cnt != '0) ? RUN : DONE;
            RUN: begin
                if (nan_hit)
                    state_nxt = DONE;
                else if (cnt == LEN_W'(1))
                    state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses and the remaining-pair count advance once per issued read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_a   <= '0;
            addr_b   <= '0;
            cnt      <= '0;
            mac_en_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            mac_en_q <= mem_rd_en;
            if (accept) begin
                addr_a <= base_a;
                addr_b <= base_b;
                cnt    <= len;
            end else if (mem_rd_en) begin
                addr_a <= addr_a + ADDR_W'(1);
                addr_b <= addr_b + ADDR_W'(1);
                cnt    <= cnt - LEN_W'(1);
            end
        end
    end

`ifdef BF_SEQ_NAN_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_nan <= 1'b0;
        else if (accept || ((state == DONE) && res_ready))
            res_nan <= 1'b0;
        else if (nan_hit)
            res_nan <= 1'b1;
    end
`endif

    // A NaN seen in RUN suppresses the read in that same cycle, so mac_en falls one cycle later.
    assign mem_rd_en  = (state == RUN) && !nan_hit;
    assign mem_a_addr = addr_a;
    assign mem_b_addr = addr_b;
    assign mac_en     = mac_en_q;
    assign mac_clr    = (state == CLEAR);
    assign mac_in_1   = mem_a_rdata;
    assign mac_in_2   = mem_b_rdata;
    assign busy       = (state != IDLE);
    assign res_valid  = (state == DONE);
    assign res_data   = res_valid ? acc_result : '0;

endmodule

// File: tb/tb_bf_mac_seq.sv
// Self-checking bench for bf_mac_seq with behavioural operand memories, a MAC stub and a dot-product model.
// Define BF_SEQ_NAN_ABORT_EN for both bench and RTL to exercise the NaN abort path.
module tb_bf_mac_seq;
    import bf_pkg::*;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_a_addr;
    logic [ADDR_W-1:0] mem_b_addr;
    logic [15:0]       mem_a_rdata;
    logic [15:0]       mem_b_rdata;
    logic              mac_clr;
    logic              mac_en;
    logic [15:0]       mac_in_1;
    logic [15:0]       mac_in_2;
    logic [31:0]       acc_result;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_data;
`ifdef BF_SEQ_NAN_ABORT_EN
    logic              res_nan;
`endif

    int n_checks;
    int n_fail;

    logic [15:0] mem_a [DEPTH];
    logic [15:0] mem_b [DEPTH];
    logic [15:0] value_tbl [8];

    real acc;
    bit  acc_nan;

    bf_mac_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_a      (base_a),
        .base_b      (base_b),
        .len         (len),
        .busy        (busy),
        .mem_rd_en   (mem_rd_en),
        .mem_a_addr  (mem_a_addr),
        .mem_b_addr  (mem_b_addr),
        .mem_a_rdata (mem_a_rdata),
        .mem_b_rdata (mem_b_rdata),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .mac_in_1    (mac_in_1),
        .mac_in_2    (mac_in_2),
        .acc_result  (acc_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data)
`ifdef BF_SEQ_NAN_ABORT_EN
        ,
        .res_nan     (res_nan)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real bf16_to_real(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        e = int'(h[14:7]);
        v = 1.0 + real'(int'(h[6:0])) / 128.0;
        for (int k = 127; k < e; k++) v = v * 2.0;
        for (int k = e; k < 127; k++) v = v / 2.0;
        return h[15] ? -v : v;
    endfunction

    function automatic logic [31:0] real_to_fp32(input real x);
        logic [31:0] r;
        logic [31:0] m;
        real         v;
        int          e;
        if (x == 0.0) return 32'd0;
        r[31] = (x < 0.0);
        v = (x < 0.0) ? -x : x;
        e = 127;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        m = 32'(longint'((v - 1.0) * 8388608.0));
        r[30:23] = e[7:0];
        r[22:0]  = m[22:0];
        return r;
    endfunction

    function automatic bit bf16_is_nan(input logic [15:0] h);
        return (h[14:7] == 8'hFF) && (h[6:0] != 7'd0);
    endfunction

    // Operand memories: synchronous read, data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_a_rdata <= mem_a[mem_a_addr];
            mem_b_rdata <= mem_b[mem_b_addr];
        end
    end

    // Stand-in for bf_mac: registered accumulator with sticky NaN.
    always @(posedge clk) begin
        if (mac_clr) begin
            acc        <= 0.0;
            acc_nan    <= 1'b0;
            acc_result <= 32'd0;
        end else if (mac_en) begin
            acc     <= acc + bf16_to_real(mac_in_1) * bf16_to_real(mac_in_2);
            acc_nan <= acc_nan | bf16_is_nan(mac_in_1) | bf16_is_nan(mac_in_2);
            acc_result <= (acc_nan | bf16_is_nan(mac_in_1) | bf16_is_nan(mac_in_2)) ? FP32_QNAN
                          : real_to_fp32(acc + bf16_to_real(mac_in_1) * bf16_to_real(mac_in_2));
        end
    end

    function automatic logic [31:0] dot_model(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb,
                                              input int n);
        real s;
        s = 0.0;
        for (int i = 0; i < n; i++)
            s = s + bf16_to_real(mem_a[(int'(ba) + i) % DEPTH]) * bf16_to_real(mem_b[(int'(bb) + i) % DEPTH]);
        return real_to_fp32(s);
    endfunction

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_rd_en"}, mem_rd_en, 1'b0);
        check_bit({tag, "_mac_clr"}, mac_clr, 1'b0);
        check_bit({tag, "_mac_en"}, mac_en, 1'b0);
        check_bit({tag, "_res_valid"}, res_valid, 1'b0);
        check_word({tag, "_res_data"}, res_data, 32'd0);
        check_word({tag, "_addr_a"}, 32'(mem_a_addr), 32'd0);
        check_word({tag, "_addr_b"}, 32'(mem_b_addr), 32'd0);
    endtask

    // Starts a job and follows it cycle by cycle until res_valid, checking every strobe against the schedule.
    task automatic run_job(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb, input int n);
        logic [31:0]       exp_res;
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W-1:0] eb;
        int                res_cyc;
        int                exp_cyc;
        exp_res = dot_model(ba, bb, n);
        exp_cyc = (n == 0) ? 2 : n + 3;
        @(negedge clk);
        start  = 1'b1;
        base_a = ba;
        base_b = bb;
        len    = LEN_W'(n);
        @(posedge clk);
        #1 start = 1'b0;
        res_cyc = 0;
        for (int cyc = 1; cyc <= n + 10 && res_cyc == 0; cyc++) begin
            @(negedge clk);
            check_bit("mac_clr", mac_clr, cyc == 1);
            check_bit("mem_rd_en", mem_rd_en, (n != 0) && (cyc >= 2) && (cyc <= n + 1));
            check_bit("mac_en", mac_en, (n != 0) && (cyc >= 3) && (cyc <= n + 2));
            check_bit("busy", busy, 1'b1);
            if ((n != 0) && (cyc >= 2) && (cyc <= n + 1)) begin
                ea = ba + ADDR_W'(cyc - 2);
                eb = bb + ADDR_W'(cyc - 2);
                check_word("addr_a", 32'(mem_a_addr), 32'(ea));
                check_word("addr_b", 32'(mem_b_addr), 32'(eb));
            end
            if (res_valid === 1'b1) res_cyc = cyc;
        end
        check_word("res_cycle", res_cyc, exp_cyc);
        check_word("res_data", res_data, exp_res);
`ifdef BF_SEQ_NAN_ABORT_EN
        check_bit("res_nan_clean", res_nan, 1'b0);
`endif
    endtask

    task automatic handshake();
        @(negedge clk);
        check_bit("hs_valid", res_valid, 1'b1);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check_bit("hs_valid_drop", res_valid, 1'b0);
        check_bit("hs_busy_drop", busy, 1'b0);
        check_word("hs_data_zero", res_data, 32'd0);
        res_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0]       held;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        int                rn;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        start     = 1'b0;
        res_ready = 1'b0;
        base_a    = '0;
        base_b    = '0;
        len       = '0;
        acc       = 0.0;
        acc_nan   = 1'b0;
        acc_result = 32'd0;
        value_tbl = '{16'h0000, 16'h3F80, 16'h4000, 16'h4040, 16'h3F00, 16'hBF80, 16'hC000, 16'h3E80};
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = value_tbl[$urandom_range(0, 7)];
            mem_b[i] = value_tbl[$urandom_range(0, 7)];
        end

        #3 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        mem_a[0] = 16'h3F80; mem_a[1] = 16'h4000; mem_a[2] = 16'h3F80;
        mem_b[0] = 16'h4000; mem_b[1] = 16'h4000; mem_b[2] = 16'h3F80;
        run_job(10'd0, 10'd0, 3);
        check_word("plan_seven", res_data, 32'h40E0_0000);
        handshake();

        run_job(10'($urandom_range(0, DEPTH - 1)), 10'($urandom_range(0, DEPTH - 1)), 0);
        check_word("len0_zero", res_data, 32'd0);
        handshake();

        run_job(10'h3FE, 10'($urandom_range(0, DEPTH - 1)), 4);
        handshake();

        // Result must hold while the consumer stalls, and a start during DONE must not queue.
        run_job(10'd5, 10'd9, 3);
        held = dot_model(10'd5, 10'd9, 3);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = (k == 4);
            check_bit("stall_valid", res_valid, 1'b1);
            check_word("stall_data", res_data, held);
            check_bit("stall_busy", busy, 1'b1);
        end
        handshake();
        repeat (3) begin
            @(negedge clk);
            check_bit("no_queue_busy", busy, 1'b0);
        end

        @(negedge clk);
        start = 1'b1; base_a = 10'd20; base_b = 10'd30; len = 10'd8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1 check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_job(10'd20, 10'd30, 8);
        handshake();

        for (int j = 0; j < 6; j++) begin
            ra = 10'($urandom_range(0, DEPTH - 1));
            rb = 10'($urandom_range(0, DEPTH - 1));
            rn = int'($urandom_range(0, 20));
            run_job(ra, rb, rn);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
        end

`ifdef BF_SEQ_NAN_ABORT_EN
        begin
            int nan_cyc;
            int res_cyc;
            for (int i = 100; i < 108; i++) mem_a[i] = value_tbl[$urandom_range(1, 7)];
            mem_a[101] = 16'h7FC1;
            @(negedge clk);
            start = 1'b1; base_a = 10'd100; base_b = 10'd200; len = 10'd8;
            @(posedge clk);
            #1 start = 1'b0;
            nan_cyc = 0;
            res_cyc = 0;
            for (int cyc = 1; cyc <= 20 && res_cyc == 0; cyc++) begin
                @(negedge clk);
                if (nan_cyc != 0 && cyc == nan_cyc + 1)
                    check_bit("nan_mac_en_drop", mac_en, 1'b0);
                if (is_fp32_nan(acc_result)) begin
                    if (nan_cyc == 0) nan_cyc = cyc;
                    check_bit("nan_rd_stop", mem_rd_en, 1'b0);
                end
                if (res_valid === 1'b1) res_cyc = cyc;
            end
            check_bit("nan_seen", nan_cyc != 0, 1'b1);
            check_bit("nan_done_early", (res_cyc > 0) && (res_cyc < 11), 1'b1);
            check_bit("nan_flag", res_nan, 1'b1);
            handshake();
            check_bit("nan_flag_clear", res_nan, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
